// File: rtl/sd_cmd_tx.sv
`timescale 1ns/1ps
// SD-bus CMD-line transmitter: frames index+argument, appends CRC7 and end bit,
// shifts MSB-first on falling edges, then holds the line idle for GAP_CYCLES clocks.
module sd_cmd_tx #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_ready,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done,
    output logic [6:0]  crc_out
);

    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, ENDB, GAP} state_t;

    localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  bitCnt_q, bitCnt_d;
    logic [7:0]  gapCnt_q, gapCnt_d;
    logic [38:0] shift_q, shift_d;
    logic [6:0]  crc_q, crc_d;
    logic [6:0]  crcOut_q, crcOut_d;
    logic        ready_q, ready_d;
    logic        out_q, out_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // One serial step of the x^7+x^3+1 generator.
    function automatic logic [6:0] crcStep(input logic [6:0] c, input logic b);
        logic g;
        g = b ^ c[6];
        return {c[5:3], c[2] ^ g, c[1:0], g};
    endfunction

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        gapCnt_d = gapCnt_q;
        shift_d  = shift_q;
        crc_d    = crc_q;
        crcOut_d = crcOut_q;
        ready_d  = ready_q;
        out_d    = out_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Bit 47 (start bit) goes out and into the CRC on the accept edge.
                    shift_d  = {1'b1, cmd_index, cmd_arg};
                    out_d    = 1'b0;
                    oe_d     = 1'b1;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    crc_d    = crcStep(7'd0, 1'b0);
                    bitCnt_d = 6'd46;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_d    = shift_q[38];
                shift_d  = {shift_q[37:0], 1'b0};
                crc_d    = crcStep(crc_q, shift_q[38]);
                bitCnt_d = bitCnt_q - 6'd1;
                if (bitCnt_q == 6'd8) begin
                    state_d = CRC;
                end
            end
            CRC: begin
                out_d    = crc_q[6];
                crc_d    = {crc_q[5:0], 1'b0};
                bitCnt_d = bitCnt_q - 6'd1;
                if (bitCnt_q == 6'd7) begin
                    crcOut_d = crc_q;
                end
                if (bitCnt_q == 6'd1) begin
                    state_d = ENDB;
                end
            end
            ENDB: begin
                out_d    = 1'b1;
                gapCnt_d = GapLoad;
                state_d  = GAP;
            end
            GAP: begin
                oe_d   = 1'b0;
                out_d  = 1'b1;
                done_d = (gapCnt_q == GapLoad);
                if (gapCnt_q == 8'd0) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Falling-edge update so the card samples a stable line on the rising edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            gapCnt_q <= '0;
            shift_q  <= '0;
            crc_q    <= '0;
            crcOut_q <= '0;
            ready_q  <= 1'b1;
            out_q    <= 1'b1;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            gapCnt_q <= gapCnt_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            crcOut_q <= crcOut_d;
            ready_q  <= ready_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign cmd_out   = out_q;
    assign cmd_oe    = oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign crc_out   = crcOut_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
`timescale 1ns/1ps
// Bench for sd_cmd_tx: a GAP_CYCLES=8 and a GAP_CYCLES=1 instance share inputs;
// frames are checked against a long-division CRC7 reference model.
module tb_sd_cmd_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    logic       ready0, out0, oe0, busy0, done0;
    logic [6:0] crc0;
    logic       ready1, out1, oe1, busy1, done1;
    logic [6:0] crc1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_cmd_tx #(.GAP_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_ready(ready0), .cmd_out(out0), .cmd_oe(oe0), .busy(busy0), .done(done0), .crc_out(crc0)
    );

    sd_cmd_tx #(.GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_ready(ready1), .cmd_out(out1), .cmd_oe(oe1), .busy(busy1), .done(done1), .crc_out(crc1)
    );

    // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] refCrc(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] refFrame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] msg;
        msg = {2'b01, idx, arg};
        return {msg, refCrc(msg), 1'b1};
    endfunction

    function automatic logic oeOf(input int which);
        return (which == 1) ? oe1 : oe0;
    endfunction

    function automatic logic outOf(input int which);
        return (which == 1) ? out1 : out0;
    endfunction

    task automatic waitIdle();
        int n;
        n = 0;
        while (!(ready0 === 1'b1 && ready1 === 1'b1) && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!(ready0 === 1'b1 && ready1 === 1'b1)) begin
            failures++;
            $display("[TB] FAIL idle_timeout ready0=%b ready1=%b required 1/1", ready0, ready1);
        end
    endtask

    // Waits (bounded) for the line to be driven, then records 48 bits at rising edges.
    task automatic capture(input int which, input bit dropValid, input bit changeInputs,
                           input logic [5:0] nIdx, input logic [31:0] nArg, input bit scramble,
                           output logic [47:0] f, output int waited, output int oeHigh,
                           output bit timedOut);
        f = '0;
        waited = 0;
        oeHigh = 0;
        timedOut = 1'b0;
        while (oeOf(which) !== 1'b1 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        if (oeOf(which) !== 1'b1) begin
            timedOut = 1'b1;
            cmd_valid = 1'b0;
            return;
        end
        if (dropValid) cmd_valid = 1'b0;
        if (changeInputs) begin
            cmd_index = nIdx;
            cmd_arg = nArg;
        end
        for (int i = 47; i >= 0; i--) begin
            f[i] = outOf(which);
            if (oeOf(which) === 1'b1) oeHigh++;
            if (scramble) begin
                cmd_index = 6'($urandom);
                cmd_arg = $urandom;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_arg = '0;
        #3;
        checks++;
        if ({out0, oe0, ready0, busy0, done0, crc0} !== {5'b10100, 7'd0}) begin
            failures++;
            $display("[TB] FAIL reset_g8 out/oe/ready/busy/done/crc=%b%b%b%b%b/%h required 10100/00",
                     out0, oe0, ready0, busy0, done0, crc0);
        end
        checks++;
        if ({out1, oe1, ready1, busy1, done1, crc1} !== {5'b10100, 7'd0}) begin
            failures++;
            $display("[TB] FAIL reset_g1 out/oe/ready/busy/done/crc=%b%b%b%b%b/%h required 10100/00",
                     out1, oe1, ready1, busy1, done1, crc1);
        end
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_fixed(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [47:0] golden, input logic [6:0] goldenCrc);
        logic [47:0] f;
        int waited, oeHigh, n, dones;
        bit to;
        waitIdle();
        cmd_index = idx;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        capture(0, 1'b1, 1'b0, '0, '0, 1'b0, f, waited, oeHigh, to);
        checks++;
        if (to) begin
            failures++;
            $display("[TB] FAIL frame_timeout cmd%0d", idx);
        end
        checks++;
        if (f !== refFrame(idx, arg)) begin
            failures++;
            $display("[TB] FAIL frame_model cmd%0d got %h required %h", idx, f, refFrame(idx, arg));
        end
        checks++;
        if (f !== golden) begin
            failures++;
            $display("[TB] FAIL frame_golden cmd%0d got %h required %h", idx, f, golden);
        end
        checks++;
        if (crc0 !== goldenCrc) begin
            failures++;
            $display("[TB] FAIL crc_out cmd%0d got %h required %h", idx, crc0, goldenCrc);
        end
        checks++;
        if (oeHigh != 48) begin
            failures++;
            $display("[TB] FAIL oe_width cmd%0d got %0d required 48", idx, oeHigh);
        end
        checks++;
        if ({oe0, out0, done0, busy0, ready0} !== 5'b01110) begin
            failures++;
            $display("[TB] FAIL gap_first oe/out/done/busy/ready=%b%b%b%b%b required 01110",
                     oe0, out0, done0, busy0, ready0);
        end
        n = 0;
        dones = 0;
        while (ready0 !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
            if (done0 === 1'b1) dones++;
        end
        checks++;
        if (n != 7 || dones != 0 || busy0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gap_tail cycles=%0d extra_done=%0d busy=%b required 7/0/0", n, dones, busy0);
        end
    endtask

    task automatic test_cmd0();
        test_fixed(6'd0, 32'h0000_0000, 48'h40_00000000_95, 7'h4A);
    endtask

    task automatic test_cmd8();
        test_fixed(6'd8, 32'h0000_01AA, 48'h48_000001AA_87, 7'h43);
    endtask

    task automatic test_back_to_back();
        logic [47:0] f;
        int waited, oeHigh;
        bit to;
        waitIdle();
        cmd_index = 6'd55;
        cmd_arg = 32'h0;
        cmd_valid = 1'b1;
        capture(0, 1'b0, 1'b1, 6'd41, 32'h4000_0000, 1'b0, f, waited, oeHigh, to);
        checks++;
        if (to || f !== refFrame(6'd55, 32'h0)) begin
            failures++;
            $display("[TB] FAIL b2b_first got %h timeout=%0d required %h", f, to, refFrame(6'd55, 32'h0));
        end
        capture(0, 1'b1, 1'b0, '0, '0, 1'b0, f, waited, oeHigh, to);
        checks++;
        if (to || waited != 8) begin
            failures++;
            $display("[TB] FAIL b2b_gap idle=%0d timeout=%0d required 8", waited, to);
        end
        checks++;
        if (f !== 48'h69_40000000_77 || f !== refFrame(6'd41, 32'h4000_0000)) begin
            failures++;
            $display("[TB] FAIL b2b_second got %h required %h", f, 48'h69_40000000_77);
        end
    endtask

    task automatic test_arg_change();
        logic [47:0] f;
        int waited, oeHigh;
        bit to;
        waitIdle();
        cmd_index = 6'd0;
        cmd_arg = 32'h0;
        cmd_valid = 1'b1;
        capture(0, 1'b1, 1'b0, '0, '0, 1'b1, f, waited, oeHigh, to);
        checks++;
        if (to || f !== 48'h40_00000000_95) begin
            failures++;
            $display("[TB] FAIL arg_change got %h timeout=%0d required %h", f, to, 48'h40_00000000_95);
        end
        checks++;
        if (crc0 !== 7'h4A) begin
            failures++;
            $display("[TB] FAIL arg_change_crc got %h required 4a", crc0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [47:0] f;
        logic [5:0]  idx;
        logic [31:0] arg;
        int waited, oeHigh, n, dones;
        bit to;
        waitIdle();
        cmd_index = 6'($urandom);
        cmd_arg = $urandom;
        cmd_valid = 1'b1;
        n = 0;
        while (oe0 !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        repeat (27) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({oe0, out0, ready0, busy0, done0} !== 5'b01100) begin
            failures++;
            $display("[TB] FAIL midframe_reset oe/out/ready/busy/done=%b%b%b%b%b required 01100",
                     oe0, out0, ready0, busy0, done0);
        end
        dones = 0;
        repeat (4) begin
            @(posedge clk);
            if (done0 === 1'b1 || oe0 !== 1'b0) dones++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            if (done0 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("[TB] FAIL midframe_no_done events=%0d required 0", dones);
        end
        idx = 6'($urandom);
        arg = $urandom;
        cmd_index = idx;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        capture(0, 1'b1, 1'b0, '0, '0, 1'b0, f, waited, oeHigh, to);
        checks++;
        if (to || f !== refFrame(idx, arg)) begin
            failures++;
            $display("[TB] FAIL after_reset_frame got %h required %h", f, refFrame(idx, arg));
        end
    endtask

    task automatic test_gap1();
        logic [47:0] f;
        logic [5:0]  idxA, idxB;
        logic [31:0] argA, argB;
        int waited, oeHigh;
        bit to;
        waitIdle();
        idxA = 6'($urandom);
        argA = $urandom;
        idxB = 6'($urandom);
        argB = $urandom;
        cmd_index = idxA;
        cmd_arg = argA;
        cmd_valid = 1'b1;
        capture(1, 1'b0, 1'b1, idxB, argB, 1'b0, f, waited, oeHigh, to);
        checks++;
        if (to || f !== refFrame(idxA, argA)) begin
            failures++;
            $display("[TB] FAIL gap1_first got %h required %h", f, refFrame(idxA, argA));
        end
        capture(1, 1'b1, 1'b0, '0, '0, 1'b0, f, waited, oeHigh, to);
        checks++;
        if (to || waited != 1) begin
            failures++;
            $display("[TB] FAIL gap1_idle idle=%0d timeout=%0d required 1", waited, to);
        end
        checks++;
        if (f !== refFrame(idxB, argB) || crc1 !== refCrc(refFrame(idxB, argB)[47:8])) begin
            failures++;
            $display("[TB] FAIL gap1_second got %h crc=%h required %h", f, crc1, refFrame(idxB, argB));
        end
    endtask

    task automatic test_random();
        logic [47:0] f, exp;
        logic [5:0]  idx;
        logic [31:0] arg;
        int waited, oeHigh;
        bit to;
        for (int k = 0; k < 6; k++) begin
            waitIdle();
            idx = 6'($urandom);
            arg = $urandom;
            exp = refFrame(idx, arg);
            cmd_index = idx;
            cmd_arg = arg;
            cmd_valid = 1'b1;
            capture(0, 1'b1, 1'b0, '0, '0, 1'b0, f, waited, oeHigh, to);
            checks++;
            if (to || f !== exp || oeHigh != 48) begin
                failures++;
                $display("[TB] FAIL random_frame%0d got %h oe=%0d required %h oe=48", k, f, oeHigh, exp);
            end
            checks++;
            if (crc0 !== exp[7:1]) begin
                failures++;
                $display("[TB] FAIL random_crc%0d got %h required %h", k, crc0, exp[7:1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_back_to_back();
        test_arg_change();
        test_reset_midframe();
        test_gap1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
